rx_serial: RTL and testbench

Serial receiver that sits directly downstream of tx_serial. It consumes the single-bit serial line that tx_serial drives and reassembles parallel words. It uses the same divisor semantics, so tx_serial and rx_serial driven with the same dvsr_i value interoperate in loopback. Each received word is presented with a one-cycle valid strobe, and malformed frames are flagged.

---
 rtl/rx_serial.sv | 181 ++++++++++++++++++
 tb/tb_rx_serial.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial.sv
// rx_serial: serial receiver. It reassembles start / DATA_W data bits (LSB first) / stop frames into words.
// Define RX_PARITY_EN to expect an even-parity bit before the stop bit and to drive parity_err_o.
module rx_serial #(
    parameter int DATA_W = 8,
    parameter int DVSR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              busy_o
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RECOVER
    } state_t;

    state_t            state, state_nxt;
    logic              sync_a, sync_b;
    logic              line;
    logic [DVSR_W-1:0] tick, tick_nxt;
    logic [DVSR_W-1:0] dvsr_lat, dvsr_nxt;
    logic [DVSR_W-1:0] half;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              ferr_nxt;
`ifdef RX_PARITY_EN
    logic              par_bit, par_nxt;
    logic              perr, perr_nxt;
`endif

    assign line   = sync_b;
    assign busy_o = (state != IDLE);

    // (dvsr+1)>>1 rewritten so it cannot overflow when dvsr is all ones
    assign half = {1'b0, dvsr_lat[DVSR_W-1:1]} + DVSR_W'(dvsr_lat[0]);

`ifdef RX_PARITY_EN
    assign parity_err_o = perr;
`else
    assign parity_err_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        dvsr_nxt  = dvsr_lat;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = data_o;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!line) begin
                    state_nxt = START;
                    dvsr_nxt  = dvsr_i;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (tick == half) begin
                    tick_nxt  = '0;
                    state_nxt = line ? IDLE : DATA;
                end else begin
                    tick_nxt = tick + DVSR_W'(1);
                end
            end
            DATA: begin
                if (tick == dvsr_lat) begin
                    tick_nxt  = '0;
                    shift_nxt = DATA_W'({line, shift} >> 1);
                    if (bit_cnt == LAST_BIT) begin
                        bit_nxt = '0;
`ifdef RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    tick_nxt = tick + DVSR_W'(1);
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (tick == dvsr_lat) begin
                    tick_nxt  = '0;
                    par_nxt   = line;
                    state_nxt = STOP;
                end else begin
                    tick_nxt = tick + DVSR_W'(1);
                end
            end
`endif
            STOP: begin
                if (tick == dvsr_lat) begin
                    tick_nxt = '0;
                    data_nxt = shift;
                    if (line) begin
                        valid_nxt = 1'b1;
`ifdef RX_PARITY_EN
                        perr_nxt  = par_bit ^ (^shift);
`endif
                        state_nxt = IDLE;
                    end else begin
                        // a low stop bit may be a break; wait for the line to go idle first
                        ferr_nxt  = 1'b1;
                        state_nxt = RECOVER;
                    end
                end else begin
                    tick_nxt = tick + DVSR_W'(1);
                end
            end
            RECOVER: begin
                if (line) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_a      <= 1'b1;
            sync_b      <= 1'b1;
            state       <= IDLE;
            tick        <= '0;
            dvsr_lat    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit     <= 1'b0;
            perr        <= 1'b0;
`endif
        end else begin
            sync_a      <= data_i;
            sync_b      <= sync_a;
            state       <= state_nxt;
            tick        <= tick_nxt;
            dvsr_lat    <= dvsr_nxt;
            bit_cnt     <= bit_nxt;
            shift       <= shift_nxt;
            data_o      <= data_nxt;
            valid_o     <= valid_nxt;
            frame_err_o <= ferr_nxt;
`ifdef RX_PARITY_EN
            par_bit     <= par_nxt;
            perr        <= perr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rx_serial.sv
// tb_rx_serial: drives serial frames into rx_serial and compares its strobes against a frame-level model.
// Honours RX_PARITY_EN in the same way as the design.
module tb_rx_serial;

    localparam int DATA_W = 8;
    localparam int DVSR_W = 16;
`ifdef RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              ferr;
        logic              perr;
        int                cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              line = 1'b1;
    logic [DVSR_W-1:0] dvsr = DVSR_W'(9);
    logic [DATA_W-1:0] data_o;
    logic              valid_o, frame_err_o, parity_err_o, busy_o;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  last_fall = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];

    rx_serial #(.DATA_W(DATA_W), .DVSR_W(DVSR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (line),
        .dvsr_i       (dvsr),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // every cycle with any strobe high becomes one observed event
    always @(negedge clk) begin
        if (valid_o || frame_err_o || parity_err_o) begin
            ev_t e;
            e.data  = data_o;
            e.valid = valid_o;
            e.ferr  = frame_err_o;
            e.perr  = parity_err_o;
            e.cyc   = cyc;
            obs_q.push_back(e);
        end
    end

    function automatic ev_t expect_frame(input logic [DATA_W-1:0] w, input logic stop_bit, input logic flip);
        ev_t e;
        e.data  = w;
        e.valid = stop_bit;
        e.ferr  = !stop_bit;
        e.perr  = stop_bit && (P == 1) && flip;
        e.cyc   = 0;
        return e;
    endfunction

    // transmitter model: each bit held for dv+1 cycles; flip inverts the even-parity bit
    task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop_bit, input logic flip,
                              input int dv, input bit scramble);
        dvsr = DVSR_W'(dv);
        line = 1'b0;
        last_fall = cyc;
        exp_q.push_back(expect_frame(w, stop_bit, flip));
        repeat (dv + 1) @(negedge clk);
        if (scramble) dvsr = DVSR_W'($urandom_range(3, 200));
        for (int i = 0; i < DATA_W; i++) begin
            line = w[i];
            repeat (dv + 1) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        line = (^w) ^ flip;
        repeat (dv + 1) @(negedge clk);
`endif
        line = stop_bit;
        repeat (dv + 1) @(negedge clk);
        dvsr = DVSR_W'(dv);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total += 5;
        if (data_o !== '0)         begin bad++; $display("[TB] FAIL reset data_o: got %h want 0", data_o); end
        if (valid_o !== 1'b0)      begin bad++; $display("[TB] FAIL reset valid_o: got %b want 0", valid_o); end
        if (frame_err_o !== 1'b0)  begin bad++; $display("[TB] FAIL reset frame_err_o: got %b want 0", frame_err_o); end
        if (parity_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset parity_err_o: got %b want 0", parity_err_o); end
        if (busy_o !== 1'b0)       begin bad++; $display("[TB] FAIL reset busy_o: got %b want 0", busy_o); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single;
        int exp_lat, got_lat;
        obs_q.delete(); exp_q.delete();
        send_frame(DATA_W'(8'hA5), 1'b1, 1'b0, 9, 1'b0);
        line = 1'b1;
        repeat (10) @(negedge clk);
        // latency counted from the first clock edge that sees the low line
        exp_lat = 2 + ((9 + 1) >> 1) + (DATA_W + P + 1) * (9 + 1) + 1;
        got_lat = (obs_q.size() > 0) ? obs_q[0].cyc - last_fall - 1 : -1;
        total++;
        if (got_lat !== exp_lat) begin bad++; $display("[TB] FAIL single latency: got %0d want %0d", got_lat, exp_lat); end
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL single count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size()) begin
                bad++; $display("[TB] FAIL single ev%0d: missing, want data=%h", i, exp_q[i].data);
            end else if ({obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr} !==
                         {exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr}) begin
                bad++; $display("[TB] FAIL single ev%0d: got data=%h v=%b fe=%b pe=%b want data=%h v=%b fe=%b pe=%b", i,
                    obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr, exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] words [4];
        words[0] = DATA_W'(8'h00); words[1] = DATA_W'(8'hFF); words[2] = DATA_W'(8'h3C); words[3] = DATA_W'(8'h81);
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 4; k++) send_frame(words[k], 1'b1, 1'b0, 15, 1'b0);
        line = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL b2b count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size()) begin
                bad++; $display("[TB] FAIL b2b ev%0d: missing, want data=%h", i, exp_q[i].data);
            end else if ({obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr} !==
                         {exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr}) begin
                bad++; $display("[TB] FAIL b2b ev%0d: got data=%h v=%b fe=%b pe=%b want data=%h v=%b fe=%b pe=%b", i,
                    obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr, exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

    task automatic test_glitch;
        bit saw_busy = 1'b0;
        int waited = 0;
        obs_q.delete();
        dvsr = DVSR_W'(9);
        line = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_busy |= busy_o;
        end
        line = 1'b1;
        while (busy_o === 1'b1 && waited < 8) begin
            @(negedge clk);
            saw_busy |= busy_o;
            waited++;
        end
        total++;
        if (saw_busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch busy_rise: got 0 want 1"); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL glitch busy_fall: got %b after %0d cycles want 0", busy_o, waited); end
        repeat (30) @(negedge clk);
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("[TB] FAIL glitch strobes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_break;
        obs_q.delete(); exp_q.delete();
        send_frame(DATA_W'(8'h5A), 1'b0, 1'b0, 9, 1'b0);
        repeat (50) @(negedge clk);
        line = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(DATA_W'(8'h11), 1'b1, 1'b0, 9, 1'b0);
        line = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL break count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size()) begin
                bad++; $display("[TB] FAIL break ev%0d: missing, want data=%h", i, exp_q[i].data);
            end else if ({obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr} !==
                         {exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr}) begin
                bad++; $display("[TB] FAIL break ev%0d: got data=%h v=%b fe=%b pe=%b want data=%h v=%b fe=%b pe=%b", i,
                    obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr, exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [DATA_W-1:0] w = DATA_W'(8'hC3);
        obs_q.delete(); exp_q.delete();
        dvsr = DVSR_W'(9);
        line = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            line = w[i];
            repeat (10) @(negedge clk);
        end
        line = w[3];
        repeat (5) @(negedge clk);
        rst = 1'b0;
        line = 1'b1;
        #1;
        total += 5;
        if (data_o !== '0)         begin bad++; $display("[TB] FAIL midrst data_o: got %h want 0", data_o); end
        if (valid_o !== 1'b0)      begin bad++; $display("[TB] FAIL midrst valid_o: got %b want 0", valid_o); end
        if (frame_err_o !== 1'b0)  begin bad++; $display("[TB] FAIL midrst frame_err_o: got %b want 0", frame_err_o); end
        if (parity_err_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst parity_err_o: got %b want 0", parity_err_o); end
        if (busy_o !== 1'b0)       begin bad++; $display("[TB] FAIL midrst busy_o: got %b want 0", busy_o); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(DATA_W'(8'h7E), 1'b1, 1'b0, 9, 1'b0);
        line = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL midrst count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size()) begin
                bad++; $display("[TB] FAIL midrst ev%0d: missing, want data=%h", i, exp_q[i].data);
            end else if ({obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr} !==
                         {exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr}) begin
                bad++; $display("[TB] FAIL midrst ev%0d: got data=%h v=%b fe=%b pe=%b want data=%h v=%b fe=%b pe=%b", i,
                    obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr, exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

    // random words, divisors, stop bits and parity flips; dvsr_i is scrambled mid-frame
    task automatic test_random;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 12; k++) begin
            int          dv;
            logic        stop_bit;
            int          gap;
            dv       = int'($urandom_range(3, 20));
            stop_bit = ($urandom_range(0, 3) != 0);
            send_frame(DATA_W'($urandom), stop_bit, 1'($urandom_range(0, 1)), dv, 1'b1);
            gap = stop_bit ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 12));
            line = 1'b1;
            repeat (gap) @(negedge clk);
        end
        line = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size()) begin
                bad++; $display("[TB] FAIL random ev%0d: missing, want data=%h", i, exp_q[i].data);
            end else if ({obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr} !==
                         {exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr}) begin
                bad++; $display("[TB] FAIL random ev%0d: got data=%h v=%b fe=%b pe=%b want data=%h v=%b fe=%b pe=%b", i,
                    obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr, exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity;
        obs_q.delete(); exp_q.delete();
        send_frame(DATA_W'(8'h07), 1'b1, 1'b1, 9, 1'b0);
        line = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(DATA_W'(8'h07), 1'b1, 1'b0, 9, 1'b0);
        line = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (obs_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL parity count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size()) begin
                bad++; $display("[TB] FAIL parity ev%0d: missing, want data=%h", i, exp_q[i].data);
            end else if ({obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr} !==
                         {exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr}) begin
                bad++; $display("[TB] FAIL parity ev%0d: got data=%h v=%b fe=%b pe=%b want data=%h v=%b fe=%b pe=%b", i,
                    obs_q[i].data, obs_q[i].valid, obs_q[i].ferr, obs_q[i].perr, exp_q[i].data, exp_q[i].valid, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask
`endif

    initial begin
        #2;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_random();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
